// File: rtl/tri_bus_sel_ctrl_pkg.sv
// Shared definitions for the tristate bus select controller: FSM encoding,
// counter widths and default parameter values.
package tri_bus_sel_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DRIVE = 2'd1,
    ST_TURN  = 2'd2
  } state_t;

  localparam int DEF_NUM_DRV  = 4;
  localparam int DEF_MAX_HOLD = 8;
  localparam int DEF_TURN_CYC = 1;
  localparam int DEF_ID_W     = 2;

  // Sized for the largest legal MAX_HOLD (255) and TURN_CYC (3).
  localparam int HOLD_W = 8;
  localparam int TURN_W = 2;

endpackage : tri_bus_sel_ctrl_pkg

// File: rtl/tri_rr_pick.sv
// Combinational round-robin picker: first set req bit searching upward from
// ptr+1 with wrap-around, so the driver at ptr itself has lowest priority.
module tri_rr_pick
  import tri_bus_sel_ctrl_pkg::*;
#(
  parameter int NUM_DRV = DEF_NUM_DRV,
  parameter int ID_W    = DEF_ID_W
) (
  input  logic [NUM_DRV-1:0] req,
  input  logic [ID_W-1:0]    ptr,
  output logic               found,
  output logic [ID_W-1:0]    idx
);

  // Walk from the farthest candidate to the nearest so the nearest set bit
  // is the last one written and therefore wins.
  always_comb begin
    // NOTE: every variable written here gets a default first; a path that
    // leaves one unassigned would infer a latch.
    idx = '0;
    for (int i = NUM_DRV; i >= 1; i--) begin
      if (req[(int'(ptr) + i) % NUM_DRV]) begin
        idx = ID_W'((int'(ptr) + i) % NUM_DRV);
      end
    end
  end

  assign found = |req;

endmodule : tri_rr_pick

// File: rtl/tri_bus_sel_ctrl.sv
// Round-robin owner select for a bank of tristate drivers on one shared net,
// with bounded hold and dead turnaround cycles between owners. Defining
// TRI_BUS_SEL_CTRL_CONTENTION_CHK_EN adds a sticky contention checker on err.
module tri_bus_sel_ctrl
  import tri_bus_sel_ctrl_pkg::*;
#(
  parameter int NUM_DRV  = DEF_NUM_DRV,
  parameter int MAX_HOLD = DEF_MAX_HOLD,
  parameter int TURN_CYC = DEF_TURN_CYC,
  parameter int ID_W     = DEF_ID_W
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_DRV-1:0] req,
  output logic [NUM_DRV-1:0] en_hi,
  output logic [NUM_DRV-1:0] en_lo_n,
  output logic [ID_W-1:0]    gnt_id,
  output logic               bus_busy,
  output logic               err
);

  localparam logic [HOLD_W-1:0] HOLD_MAX  = HOLD_W'(MAX_HOLD);
  localparam logic [HOLD_W-1:0] HOLD_ONE  = HOLD_W'(1);
  localparam logic [TURN_W-1:0] TURN_LAST = TURN_W'(TURN_CYC);
  localparam logic [TURN_W-1:0] TURN_ONE  = TURN_W'(1);
  localparam logic [ID_W-1:0]   PTR_RST   = ID_W'(NUM_DRV - 1);

  state_t             state_q, state_d;
  logic [ID_W-1:0]    owner_q, owner_d;
  logic [ID_W-1:0]    ptr_q, ptr_d;
  logic [HOLD_W-1:0]  hold_q, hold_d;
  logic [TURN_W-1:0]  turn_q, turn_d;

  logic [NUM_DRV-1:0] en_hi_d;
  logic [NUM_DRV-1:0] en_lo_n_d;
  logic [ID_W-1:0]    gnt_id_d;
  logic               busy_d;

  logic               pick_found;
  logic [ID_W-1:0]    pick_idx;
  logic [NUM_DRV-1:0] owner_mask;
  logic               owner_req;
  logic               others_req;

  tri_rr_pick #(
    .NUM_DRV (NUM_DRV),
    .ID_W    (ID_W)
  ) u_pick (
    .req   (req),
    .ptr   (ptr_q),
    .found (pick_found),
    .idx   (pick_idx)
  );

  assign owner_mask = NUM_DRV'(1) << owner_q;
  assign owner_req  = |(req & owner_mask);
  assign others_req = |(req & ~owner_mask);

  // State register; the output pins are registered here too so nothing
  // reaches them combinationally from req.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: every register, enables included, has an async reset so the
    // drivers release the net the instant rst_n falls.
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      owner_q  <= '0;
      ptr_q    <= PTR_RST;
      hold_q   <= '0;
      turn_q   <= '0;
      en_hi    <= '0;
      en_lo_n  <= '1;
      gnt_id   <= '0;
      bus_busy <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples the
      // pre-edge values regardless of statement order.
      state_q  <= state_d;
      owner_q  <= owner_d;
      ptr_q    <= ptr_d;
      hold_q   <= hold_d;
      turn_q   <= turn_d;
      en_hi    <= en_hi_d;
      en_lo_n  <= en_lo_n_d;
      gnt_id   <= gnt_id_d;
      bus_busy <= busy_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    ptr_d   = ptr_q;
    hold_d  = hold_q;
    turn_d  = turn_q;
    unique case (state_q)
      ST_IDLE: begin
        if (pick_found) begin
          state_d = ST_DRIVE;
          owner_d = pick_idx;
          hold_d  = HOLD_ONE;
        end
      end
      ST_DRIVE: begin
        // A drop coinciding with the hold limit takes the same exit.
        if (!owner_req || (hold_q == HOLD_MAX && others_req)) begin
          state_d = ST_TURN;
          ptr_d   = owner_q;
          turn_d  = TURN_ONE;
        end else if (hold_q != HOLD_MAX) begin
          hold_d = hold_q + HOLD_ONE;
        end
      end
      ST_TURN: begin
        if (turn_q == TURN_LAST) begin
          if (pick_found) begin
            state_d = ST_DRIVE;
            owner_d = pick_idx;
            hold_d  = HOLD_ONE;
          end else begin
            state_d = ST_IDLE;
          end
        end else begin
          turn_d = turn_q + TURN_ONE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Output logic, computed from the next state so the pins register in step
  // with the state they describe.
  always_comb begin
    busy_d    = (state_d == ST_DRIVE);
    en_hi_d   = busy_d ? (NUM_DRV'(1) << owner_d) : '0;
    en_lo_n_d = ~en_hi_d;
    gnt_id_d  = owner_d;
  end

`ifdef TRI_BUS_SEL_CTRL_CONTENTION_CHK_EN
  logic [NUM_DRV-1:0] prev_en_q;
  logic               multi_hot;
  logic               hot_swap;

  assign multi_hot = |(en_hi & (en_hi - NUM_DRV'(1)));
  // Owner A to owner B with no dead cycle in between.
  assign hot_swap  = (|prev_en_q) && (|en_hi) && (prev_en_q != en_hi);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev_en_q <= '0;
      err       <= 1'b0;
    end else begin
      prev_en_q <= en_hi;
      if (multi_hot || hot_swap) begin
        err <= 1'b1;
      end
    end
  end
`else
  assign err = 1'b0;
`endif

endmodule : tri_bus_sel_ctrl

// File: doc/tri_bus_sel_ctrl.md
Name: tri_bus_sel_ctrl

Overview:
- Sequential controller that drives the select/enable pins of a bank of tristate primitive drivers (bufif1/notif1 active-high, bufif0/notif0 active-low) sharing one net.
- Sits directly upstream of the primitive driver stage and produces its sel inputs.
- Round-robin arbitration among requesters, with a bounded hold time per grant.
- Inserts turnaround cycles between owners so that two drivers never enable on the same cycle.

Parameters:
- NUM_DRV, 4: number of tristate drivers/requesters (2..8).
- MAX_HOLD, 8: maximum consecutive DRIVE cycles per grant while others are requesting (1..255).
- TURN_CYC, 1: dead cycles (all drivers off) between owners (1..3).
- ID_W, 2: width of gnt_id, equal to clog2(NUM_DRV) and at least 1.

Ports:
- clk, input, 1: rising-edge clock.
- rst_n, input, 1: asynchronous active-low reset.
- req, input, NUM_DRV: request vector; bit i means driver i wants the bus. Level-sensitive.
- en_hi, output, NUM_DRV: one-hot-or-zero enables for bufif1/notif1 sel.
- en_lo_n, output, NUM_DRV: bitwise inverse of en_hi, for bufif0/notif0 sel.
- gnt_id, output, ID_W: index of the current owner; valid only when bus_busy=1.
- bus_busy, output, 1: high in DRIVE state.
- err, output, 1: sticky contention flag (see Optional Feature).

Behaviour:
- Reset (async assert, synchronous-safe release):
  - state=IDLE, en_hi=0, en_lo_n=all 1s, gnt_id=0, bus_busy=0, err=0.
  - Round-robin pointer = NUM_DRV-1, so driver 0 has first priority.
- All outputs are registered. No combinational path from req to any output.
- States IDLE, DRIVE, TURN:
  - IDLE:
    - If req is nonzero, pick the first set bit searching upward from pointer+1 with wrap.
    - Load owner and set hold_cnt=1; next cycle is DRIVE with en_hi[owner]=1.
    - Latency from req sampled high to enable = 1 cycle.
  - DRIVE: en_hi[owner]=1, bus_busy=1. Each cycle:
    - If req[owner]=0: go to TURN and set pointer=owner.
    - Else if hold_cnt==MAX_HOLD and some other req bit is set: go to TURN and set pointer=owner (forced rotation).
    - Else stay and increment hold_cnt, saturating at MAX_HOLD.
    - A sole requester keeps the bus indefinitely.
  - TURN:
    - en_hi=0, bus_busy=0. turn_cnt counts TURN_CYC cycles.
    - On the last TURN cycle, if req is nonzero, arbitrate as in IDLE and go to DRIVE; otherwise go to IDLE.
    - Requests that rise during TURN are honoured at the end of TURN. The TURN period is never shortened.
- Round-robin fairness: the previous owner has the lowest priority in the next arbitration.
- Simultaneous events:
  - Owner drops req in the same cycle the hold limit is reached: handled as the drop, with the same TURN.
  - req changes in the arbitration cycle: the value sampled at that edge is used.
- Invariant: en_lo_n == ~en_hi on every cycle, including reset.
- Mid-operation reset: all enables drop asynchronously on rst_n falling. No partial TURN is required.

Optional Feature:
- Macro: TRI_BUS_SEL_CTRL_CONTENTION_CHK_EN.
- Defined: a registered checker sets err=1 when either condition holds:
  - more than one en_hi bit is high in a cycle;
  - en_hi changes from owner A to a different owner B with no all-zero cycle between them.
  err stays set until rst_n.
- Undefined: err is tied to constant 0 and no checker logic is synthesised.

Decomposition:
- Shared package/header holds:
  - state encoding constants ST_IDLE=2'd0, ST_DRIVE=2'd1, ST_TURN=2'd2;
  - default parameter values.
- One natural sub-module: tri_rr_pick. It is combinational; given req and pointer it returns found and index, using wrap-around priority search. The top instantiates it once.

Test Plan:
1. Reset with req=4'b1111, then release rst_n → the cycle after release gives en_hi=0001, gnt_id=0; en_lo_n=1110 throughout.
2. req=4'b0100 held for 3 cycles then dropped → en_hi=0100 for 3 cycles, then TURN_CYC cycles of 0000, then IDLE; bus_busy mirrors this.
3. req=4'b1111 held constantly, MAX_HOLD=8 → grants rotate 0,1,2,3,0, each 8 cycles long, separated by exactly 1 all-zero cycle.
4. req=4'b0010 alone for 20 cycles → en_hi=0010 for all 20 cycles, with no forced rotation.
5. During DRIVE of owner 2, pulse rst_n low mid-cycle → en_hi=0000 and en_lo_n=1111 immediately (async); after release, arbitration restarts from driver 0.
6. With the macro defined, force the internal owner register to create a back-to-back owner change → err=1 and stays high until reset. With the macro undefined, err stays 0.
